// File: rtl/npu_sdram_pkg.sv
// Shared SDRAM-side definitions for the NPU write-back path: word geometry,
// burst-count width and the write-back FSM state type.
package npu_sdram_pkg;

  localparam int SDRAM_DATA_W         = 128;
  localparam int SDRAM_BYTES_PER_WORD = SDRAM_DATA_W / 8;
  localparam int BURSTCNT_W           = 11;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    START,
    XFER,
    WAIT_DONE
  } wb_state_t;

endpackage

// File: rtl/wb_sync_fifo.sv
// Synchronous show-ahead FIFO: rd_data always presents the head word, and a pop
// advances it on the next edge. Push into full or pop from empty is dropped.
module wb_sync_fifo #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         pop,
  output logic [DATA_W-1:0]            rd_data,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; pointers and count alone define
  // which entries are valid, so clearing them flushes the FIFO.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_wb_buffer.sv
// Buffers NPU result words and drains them to the SDRAM wrapper as write bursts
// of up to BURST_MAX words. Define WB_STATS_EN to add burst/stall counters.
module sdram_wb_buffer #(
  parameter int SDRAM_DATA_W = npu_sdram_pkg::SDRAM_DATA_W,
  parameter int FIFO_DEPTH   = 16,
  parameter int BURST_MAX    = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cfg_start,
  input  logic [31:0]                           cfg_addr,
  input  logic [15:0]                           cfg_cnt,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [SDRAM_DATA_W-1:0]               in_data,
  output logic [31:0]                           rw_addr,
  output logic [npu_sdram_pkg::BURSTCNT_W-1:0]  rw_cnt,
  output logic                                  write_start,
  input  logic                                  write_nxt,
  output logic [SDRAM_DATA_W-1:0]               write_data,
  input  logic                                  rw_done,
`ifdef WB_STATS_EN
  output logic [15:0]                           stat_bursts,
  output logic [31:0]                           stat_stall,
`endif
  output logic                                  busy,
  output logic                                  done
);
  import npu_sdram_pkg::*;

  localparam int CW             = $clog2(FIFO_DEPTH) + 1;
  localparam int BYTES_PER_WORD = SDRAM_DATA_W / 8;

  wb_state_t              state_q, state_d;
  logic [31:0]            addr_q;
  logic [15:0]            remaining_q, job_len_q, accepted_q, want;
  logic [BURSTCNT_W-1:0]  pop_cnt_q;
  logic                   rw_done_seen_q, done_zero_q;
  logic                   fin, push, pop, job_go;
  logic                   fifo_full, fifo_empty;
  logic [CW-1:0]          fifo_count;

  assign want        = (remaining_q > 16'(BURST_MAX)) ? 16'(BURST_MAX) : remaining_q;
  assign busy        = (state_q != IDLE);
  assign in_ready    = busy && !fifo_full && (accepted_q < job_len_q);
  assign push        = in_valid && in_ready;
  assign pop         = (state_q == XFER) && write_nxt && !fifo_empty;
  assign job_go      = (state_q == IDLE) && cfg_start && (cfg_cnt != '0);
  assign write_start = (state_q == START);
  assign done        = done_zero_q || (fin && state_d == IDLE);

  wb_sync_fifo #(
    .DATA_W (SDRAM_DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (in_data),
    .pop     (pop),
    .rd_data (write_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value held and infer a latch.
  always_comb begin
    state_d = state_q;
    fin     = 1'b0;
    case (state_q)
      IDLE:      if (job_go) state_d = FILL;
      FILL:      if (16'(fifo_count) >= want) state_d = START;
      START:     state_d = XFER;
      XFER:      if (pop && pop_cnt_q == rw_cnt - 1'b1) state_d = WAIT_DONE;
      WAIT_DONE: begin
        // An rw_done seen during XFER is honoured here, after the last pop.
        if (rw_done || rw_done_seen_q) begin
          fin     = 1'b1;
          state_d = (remaining_q > 16'(rw_cnt)) ? FILL : IDLE;
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      remaining_q    <= '0;
      job_len_q      <= '0;
      accepted_q     <= '0;
      pop_cnt_q      <= '0;
      rw_done_seen_q <= 1'b0;
      done_zero_q    <= 1'b0;
      rw_addr        <= '0;
      rw_cnt         <= '0;
    end else begin
      state_q     <= state_d;
      done_zero_q <= (state_q == IDLE) && cfg_start && (cfg_cnt == '0);
      if (job_go) begin
        addr_q      <= cfg_addr;
        remaining_q <= cfg_cnt;
        job_len_q   <= cfg_cnt;
        accepted_q  <= '0;
      end
      if (push) accepted_q <= accepted_q + 16'd1;
      if (state_q == FILL && state_d == START) begin
        rw_addr   <= addr_q;
        rw_cnt    <= want[BURSTCNT_W-1:0];
        pop_cnt_q <= '0;
      end
      if (pop) pop_cnt_q <= pop_cnt_q + 1'b1;
      if (state_q == XFER && rw_done) rw_done_seen_q <= 1'b1;
      if (fin) begin
        addr_q         <= addr_q + 32'(rw_cnt) * 32'(BYTES_PER_WORD);
        remaining_q    <= remaining_q - 16'(rw_cnt);
        rw_done_seen_q <= 1'b0;
      end
    end
  end

`ifdef WB_STATS_EN
  // Saturating counters; only rst clears them, never a new job.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_bursts <= '0;
      stat_stall  <= '0;
    end else begin
      if (write_start && stat_bursts != '1) stat_bursts <= stat_bursts + 1'b1;
      if (busy && in_valid && !in_ready && stat_stall != '1) stat_stall <= stat_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_wb_buffer.sv
// Directed + randomized bench for sdram_wb_buffer: a source feeding result words,
// an SDRAM wrapper emulation, and a queue-based model of bursts and data order.
module tb_sdram_wb_buffer;
  localparam int W = 128;

  logic          clk = 1'b0;
  logic          rst, cfg_start, in_valid, write_nxt, rw_done;
  logic [31:0]   cfg_addr;
  logic [15:0]   cfg_cnt;
  logic [W-1:0]  in_data, write_data;
  logic          in_ready, write_start, busy, done;
  logic [31:0]   rw_addr;
  logic [10:0]   rw_cnt;
`ifdef WB_STATS_EN
  logic [15:0]   stat_bursts;
  logic [31:0]   stat_stall;
`endif

  always #5 clk = ~clk;

  sdram_wb_buffer dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_addr(cfg_addr), .cfg_cnt(cfg_cnt),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rw_addr(rw_addr), .rw_cnt(rw_cnt), .write_start(write_start),
    .write_nxt(write_nxt), .write_data(write_data), .rw_done(rw_done),
`ifdef WB_STATS_EN
    .stat_bursts(stat_bursts), .stat_stall(stat_stall),
`endif
    .busy(busy), .done(done)
  );

  typedef struct { logic [31:0] addr; int cnt; } burst_t;

  int vectors = 0;
  int miscompares = 0;

  burst_t        burst_q[$];
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  src_words[$];
  int            src_idx = 0, src_rate = 100;
  bit            src_en = 0, src_fire;
  int            sink_hold = 0, sink_pop_limit = -1, pops_left = 0, done_delay = 0;
  int            pops_total = 0, bursts_since_rst = 0;
  bit            early_mode = 0, burst_open = 0;
  burst_t        cur_burst;
  int            done_cnt = 0, start_cnt = 0;
  bit            busy_seen = 0, last_done_busy = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference burst plan: split the job into min(8, remaining) word bursts,
  // each advancing the byte address by 16 bytes per word with 32-bit wrap.
  task automatic plan(input logic [31:0] a, input int cnt);
    int rem = cnt;
    logic [31:0] ad = a;
    while (rem > 0) begin
      burst_t b;
      b.addr = ad;
      b.cnt  = (rem > 8) ? 8 : rem;
      burst_q.push_back(b);
      ad  = ad + 32'(b.cnt * 16);
      rem = rem - b.cnt;
    end
  endtask

  // Source: holds a beat until accepted; offers cnt+3 beats to probe the job limit.
  initial begin
    in_valid = 1'b0;
    in_data  = '0;
    forever begin
      @(negedge clk);
      src_fire = in_valid && in_ready;
      @(posedge clk); #2;
      if (rst || !src_en) begin
        in_valid = 1'b0;
        continue;
      end
      if (src_fire) begin
        exp_q.push_back(in_data);
        src_idx++;
      end
      if (!in_valid || src_fire) begin
        if (src_idx < src_words.size() && $urandom_range(1, 100) <= src_rate) begin
          in_valid = 1'b1;
          in_data  = src_words[src_idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
  end

  // SDRAM wrapper emulation: checks burst requests and popped data against the model.
  initial begin
    write_nxt = 1'b0;
    rw_done   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pops_left  = 0;
        burst_open = 0;
      end else begin
        if (write_nxt) begin
          check("fifo_nonempty_on_pop", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("write_data", write_data, exp_q.pop_front());
          pops_left--;
          pops_total++;
        end
        if (burst_open && !write_start) begin
          check("rw_addr_stable", rw_addr, cur_burst.addr);
          check("rw_cnt_stable", rw_cnt, cur_burst.cnt);
        end
        if (write_start) begin
          bursts_since_rst++;
          check("burst_expected", burst_q.size() != 0, 1);
          if (burst_q.size() != 0) begin
            cur_burst = burst_q.pop_front();
            check("rw_addr", rw_addr, cur_burst.addr);
            check("rw_cnt", rw_cnt, cur_burst.cnt);
          end
          pops_left  = rw_cnt;
          burst_open = 1;
          done_delay = $urandom_range(0, 3);
        end
      end
      @(posedge clk); #2;
      write_nxt = 1'b0;
      rw_done   = 1'b0;
      if (rst) continue;
      if (sink_hold > 0) sink_hold--;
      if (burst_open) begin
        if (pops_left > 0) begin
          if (sink_hold == 0 && sink_pop_limit != 0 && $urandom_range(0, 3) != 0) begin
            write_nxt = 1'b1;
            if (sink_pop_limit > 0) sink_pop_limit--;
            if (early_mode && pops_left == 1) begin
              rw_done    = 1'b1;
              burst_open = 0;
            end
          end
        end else if (done_delay > 0) begin
          done_delay--;
        end else begin
          rw_done    = 1'b1;
          burst_open = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        last_done_busy = busy;
      end
      if (busy) busy_seen = 1;
      if (write_start) start_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before the summary line");
    $fatal(1, "watchdog");
  end

  task automatic start_job(input logic [31:0] a, input int cnt, input int rate, input bit inc);
    src_en = 0;
    repeat (2) @(posedge clk);
    #1;
    src_words.delete();
    src_idx = 0;
    for (int i = 0; i < cnt + 3; i++)
      src_words.push_back(inc ? W'(i) : {$urandom, $urandom, $urandom, $urandom});
    src_rate = rate;
    plan(a, cnt);
    @(posedge clk); #1;
    cfg_start = 1'b1;
    cfg_addr  = a;
    cfg_cnt   = 16'(cnt);
    src_en    = 1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_job(input string tag, input int cnt);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_done_once"}, done_cnt - d0, 1);
    check({tag, "_busy_at_done"}, last_done_busy, 1);
    @(negedge clk);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_accepted"}, src_idx, cnt);
    check({tag, "_bursts_left"}, burst_q.size(), 0);
    check({tag, "_words_left"}, exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check({tag, "_no_extra_done"}, done_cnt - d0, 1);
  endtask

  initial begin
    int s0, d0, n;
    rst = 1'b1; cfg_start = 1'b0; cfg_addr = '0; cfg_cnt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_write_start", write_start, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_rw_addr", rw_addr, 0);
    check("rst_rw_cnt", rw_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Three bursts with incrementing data 0..19.
    start_job(32'h3000_0000, 20, 100, 1);
    wait_job("job20", 20);

    // Zero-length job: done one cycle after cfg_start, nothing else.
    s0 = start_cnt; d0 = done_cnt; busy_seen = 0;
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_cnt = '0; cfg_addr = 32'h1234_0000;
    @(negedge clk);
    check("zero_done_early", done, 0);
    @(posedge clk); #1;
    cfg_start = 1'b0;
    @(negedge clk);
    check("zero_done_pulse", done, 1);
    repeat (6) @(negedge clk);
    check("zero_done_count", done_cnt - d0, 1);
    check("zero_no_start", start_cnt - s0, 0);
    check("zero_busy_seen", busy_seen, 0);

    // Wrapper stalls 50 cycles: FIFO fills to 16 and in_ready drops.
    sink_hold = 50;
    start_job(32'h0000_4000, 24, 100, 0);
    repeat (40) @(negedge clk);
    check("stall_in_ready", in_ready, 0);
    check("stall_accepted", src_idx, 16);
`ifdef WB_STATS_EN
    check("stall_stat_nonzero", stat_stall > 0, 1);
`endif
    wait_job("stall", 24);

    // rw_done with the last pop, across the 32-bit address wrap.
    early_mode = 1;
    start_job(32'hFFFF_FF80, 17, 80, 0);
    wait_job("early", 17);
    early_mode = 0;

    // Reset in XFER with 5 words still buffered.
    d0 = done_cnt; s0 = pops_total; n = 0;
    sink_pop_limit = 3;
    start_job(32'h0000_1000, 8, 100, 0);
    while (pops_total - s0 < 3 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("midrst_pops", pops_total - s0, 3);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; src_en = 0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_write_start", write_start, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_rw_addr", rw_addr, 0);
    check("midrst_rw_cnt", rw_cnt, 0);
`ifdef WB_STATS_EN
    check("midrst_stat_bursts", stat_bursts, 0);
    check("midrst_stat_stall", stat_stall, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    burst_q.delete();
    sink_pop_limit = -1;
    bursts_since_rst = 0;
    check("midrst_no_done", done_cnt - d0, 0);
    start_job(32'h0000_2000, 4, 100, 0);
    wait_job("fresh", 4);

    // Randomized jobs.
    for (int j = 0; j < 5; j++) begin
      int          c = $urandom_range(1, 40);
      logic [31:0] a = {$urandom, 4'h0};
      early_mode = 1'($urandom_range(0, 1));
      sink_hold  = $urandom_range(0, 20);
      start_job(a, c, $urandom_range(30, 100), 0);
      wait_job("rand", c);
    end
    early_mode = 0;
`ifdef WB_STATS_EN
    check("stat_bursts_total", stat_bursts, bursts_since_rst);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sdram_wb_buffer.md
SDRAM_WB_BUFFER -- requirements
Module: sdram_wb_buffer

Interface
REQ-001 Parameter SDRAM_DATA_W, default 128, SDRAM word width in bits.
REQ-002 Parameter FIFO_DEPTH, default 16, buffered words; power of two, at least BURST_MAX.
REQ-003 Parameter BURST_MAX, default 8, maximum words per SDRAM write burst.
REQ-004 Port clk, input, 1, single clock; all logic rising-edge.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Port cfg_start, input, 1, one-cycle pulse starting a write-back job; ignored while busy.
REQ-007 Port cfg_addr, input, 32, job base byte address; sampled with cfg_start.
REQ-008 Port cfg_cnt, input, 16, job length in words; sampled with cfg_start.
REQ-009 Port in_valid / in_ready / in_data, input / output / SDRAM_DATA_W, valid-ready stream of result words from the NPU datapath.
REQ-010 Port rw_addr / rw_cnt, output, 32 / 11, burst byte address and burst word count to the SDRAM wrapper.
REQ-011 Port write_start, output, 1, one-cycle burst request pulse.
REQ-012 Port write_nxt, input, 1, wrapper consumed write_data this cycle.
REQ-013 Port write_data, output, SDRAM_DATA_W, FIFO head word in show-ahead mode.
REQ-014 Port rw_done, input, 1, one-cycle pulse when the current burst is finished.
REQ-015 Ports busy / done, output, 1 each; busy: job active; done: one-cycle pulse at job end.

Function
REQ-016 FSM states: IDLE, FILL, START, XFER, WAIT_DONE.
REQ-017 IDLE: on cfg_start with cfg_cnt>0, latch addr and remaining=cfg_cnt, go to FILL, raise busy the next cycle.
REQ-018 cfg_start with cfg_cnt==0: stay in IDLE, pulse done one cycle later, busy stays 0.
REQ-019 in_ready = busy AND fifo not full AND words_accepted < job length; beats beyond cfg_cnt are never accepted.
REQ-020 FILL to START when fifo_count >= min(BURST_MAX, remaining); burst length blen = min(BURST_MAX, remaining).
REQ-021 START: drive rw_addr = current addr and rw_cnt = blen, pulse write_start for exactly one cycle, go to XFER.
REQ-022 XFER: each write_nxt pops one word; write_data shows the next head the following cycle; after blen pops go to WAIT_DONE.
REQ-023 write_nxt while the FIFO is empty is a protocol error: ignore the pop; pointers do not move.
REQ-024 WAIT_DONE on rw_done: addr += blen*(SDRAM_DATA_W/8) with 32-bit wrap; remaining -= blen; go to FILL if remaining>0, else IDLE with a done pulse that cycle and busy low the next cycle.
REQ-025 rw_done arriving in XFER before all pops completes is treated as arriving in WAIT_DONE after the final pop (latched).
REQ-026 Simultaneous push and pop on one cycle: fifo_count unchanged, both take effect; a push into a full FIFO is impossible because in_ready is 0.
REQ-027 rw_addr and rw_cnt hold stable from START until rw_done.

Reset
REQ-028 On rst: state IDLE, FIFO empty, busy=0, done=0, write_start=0, in_ready=0, rw_addr=0, rw_cnt=0, counters 0.
REQ-029 rst asserted mid-job aborts at once; buffered words are discarded; no done pulse.

Configuration
REQ-030 With macro WB_STATS_EN defined: add outputs stat_bursts (16 bits, bursts issued) and stat_stall (32 bits, cycles with in_valid=1 and in_ready=0 while busy). Both saturate, clear on rst, and never clear on cfg_start.
REQ-031 Without WB_STATS_EN: those ports and counters do not exist; all other behaviour is identical.

Structure
REQ-032 Shared package npu_sdram_pkg holds SDRAM_DATA_W, SDRAM_BYTES_PER_WORD, BURSTCNT_W=11, and the wb_state_t enum.
REQ-033 One sub-module, wb_sync_fifo: a synchronous show-ahead FIFO with count, full and empty outputs.

Verification
REQ-034 cfg_addr=0x3000_0000, cfg_cnt=20, continuous input -> bursts (0x3000_0000,8), (0x3000_0080,8), (0x3000_0100,4); one done pulse after the third rw_done.
REQ-035 cfg_cnt=0 -> no write_start; done pulses once; busy stays 0.
REQ-036 Wrapper write_nxt held low for 50 cycles with input streaming -> in_ready drops after 16 accepted words; no data loss; stat_stall > 0 when WB_STATS_EN is defined.
REQ-037 rw_done pulsed in the same cycle as the last write_nxt -> next burst starts correctly; address advances once.
REQ-038 rst asserted in XFER with 5 words buffered -> all outputs at reset values next cycle; a new job then writes fresh data only.
REQ-039 in_data incrementing pattern 0..19 -> write_data sequence observed on write_nxt is exactly 0..19 in order.
